// File: rtl/data_cache_if.sv
// data_cache_if: pipeline-side and memory-side signals of the data cache.
interface data_cache_if;
  logic         read_2DC;
  logic         write_2DC;
  logic         flush_2DC;
  logic [31:0]  data_address_2DC;
  logic [31:0]  data_write_2DC;
  logic [1:0]   data_write_size_2DC;
  logic [31:0]  data_read_fDC;
  logic         data_valid_fDC;
  logic         flush_done;
  logic         dBlkRead;
  logic         dBlkWrite;
  logic [31:0]  block_address_2DM;
  logic [255:0] block_write_2DM;
  logic [255:0] block_read_fDM;
  logic         block_read_fDM_valid;
  logic         block_write_fDM_valid;
  modport slave (
    input  read_2DC, write_2DC, flush_2DC, data_address_2DC, data_write_2DC, data_write_size_2DC,
    input  block_read_fDM, block_read_fDM_valid, block_write_fDM_valid,
    output data_read_fDC, data_valid_fDC, flush_done, dBlkRead, dBlkWrite, block_address_2DM, block_write_2DM
  );
  modport master (
    output read_2DC, write_2DC, flush_2DC, data_address_2DC, data_write_2DC, data_write_size_2DC,
    output block_read_fDM, block_read_fDM_valid, block_write_fDM_valid,
    input  data_read_fDC, data_valid_fDC, flush_done, dBlkRead, dBlkWrite, block_address_2DM, block_write_2DM
  );
endinterface

// File: rtl/data_cache.sv
// data_cache: direct-mapped write-back write-allocate cache with flush; DC_PERF_CNT_EN adds hit/miss counters.
module data_cache #(
  parameter int LINES = 32
) (
  input  logic        CLK,
  input  logic        RESET,
`ifdef DC_PERF_CNT_EN
  output logic [31:0] hit_count,
  output logic [31:0] miss_count,
`endif
  data_cache_if.slave bus
);
  localparam int IW = $clog2(LINES);
  localparam int TW = 27 - IW;
  typedef enum logic [2:0] {IDLE, WRITEBACK, REFILL, FLUSH_CHECK, FLUSH_WB, FLUSH_DONE} state_t;
  state_t          r_state, w_next;
  logic [LINES-1:0] r_valid, r_dirty;
  logic [TW-1:0]   r_tag [LINES];
  logic [255:0]    r_data [LINES];
  logic [IW-1:0]   r_scan;
  logic [IW-1:0]   w_idx, w_vidx;
  logic [TW-1:0]   w_tag;
  logic [2:0]      w_word, w_n;
  logic [5:0]      w_shl;
  logic [4:0]      w_shr;
  logic            w_req, w_hit, w_serve, w_store, w_fill, w_scan_dirty, w_scan_last, w_adv, w_wb;
  logic [31:0]     w_old, w_mask, w_merged;
  logic [255:0]    w_line;
  assign w_idx        = bus.data_address_2DC[IW+4:5];
  assign w_tag        = bus.data_address_2DC[31:IW+5];
  assign w_word       = bus.data_address_2DC[4:2];
  assign w_req        = bus.read_2DC || bus.write_2DC;
  assign w_hit        = r_valid[w_idx] && r_tag[w_idx] == w_tag;
  assign w_serve      = r_state == IDLE && !bus.flush_2DC && w_req && w_hit;
  assign w_store      = w_serve && bus.write_2DC;
  assign w_fill       = r_state == REFILL && bus.block_read_fDM_valid;
  assign w_scan_dirty = r_valid[r_scan] && r_dirty[r_scan];
  assign w_scan_last  = r_scan == IW'(LINES - 1);
  assign w_adv        = (r_state == FLUSH_CHECK && !w_scan_dirty) || (r_state == FLUSH_WB && bus.block_write_fDM_valid);
  assign w_old        = r_data[w_idx][w_word*32 +: 32];
  // Big-endian lanes: left-justify the N store bytes, then slide them right to the byte offset.
  assign w_n          = bus.data_write_size_2DC == 2'd0 ? 3'd4 : {1'b0, bus.data_write_size_2DC};
  assign w_shl        = {3'd4 - w_n, 3'b000};
  assign w_shr        = {bus.data_address_2DC[1:0], 3'b000};
  assign w_mask       = (32'hFFFF_FFFF << w_shl) >> w_shr;
  assign w_merged     = (w_old & ~w_mask) | (((bus.data_write_2DC << w_shl) >> w_shr) & w_mask);
  always_comb begin
    w_line = r_data[w_idx];
    w_line[w_word*32 +: 32] = w_merged;
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:        w_next = bus.flush_2DC ? FLUSH_CHECK :
                            (w_req && !w_hit) ? ((r_valid[w_idx] && r_dirty[w_idx]) ? WRITEBACK : REFILL) : IDLE;
      WRITEBACK:   w_next = bus.block_write_fDM_valid ? REFILL : WRITEBACK;
      REFILL:      w_next = bus.block_read_fDM_valid ? IDLE : REFILL;
      FLUSH_CHECK: w_next = w_scan_dirty ? FLUSH_WB : w_scan_last ? FLUSH_DONE : FLUSH_CHECK;
      FLUSH_WB:    w_next = bus.block_write_fDM_valid ? (w_scan_last ? FLUSH_DONE : FLUSH_CHECK) : FLUSH_WB;
      default:     w_next = IDLE;
    endcase
  end
  assign w_wb                  = r_state == WRITEBACK || r_state == FLUSH_WB;
  assign w_vidx                = r_state == FLUSH_WB ? r_scan : w_idx;
  assign bus.dBlkWrite         = w_wb;
  assign bus.dBlkRead          = r_state == REFILL;
  assign bus.flush_done        = r_state == FLUSH_DONE;
  assign bus.data_valid_fDC    = r_state == IDLE && !bus.flush_2DC && (!w_req || w_hit);
  assign bus.data_read_fDC     = w_serve ? w_old : 32'd0;
  assign bus.block_address_2DM = w_wb ? {r_tag[w_vidx], w_vidx, 5'b0} : bus.dBlkRead ? {w_tag, w_idx, 5'b0} : 32'd0;
  assign bus.block_write_2DM   = w_wb ? r_data[w_vidx] : 256'd0;
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= IDLE;
      r_valid <= '0;
      r_dirty <= '0;
      r_scan  <= '0;
    end else begin
      r_state <= w_next;
      if (w_store) r_dirty[w_idx] <= 1'b1;
      if (w_fill) begin
        r_valid[w_idx] <= 1'b1;
        r_dirty[w_idx] <= 1'b0;
      end
      if (w_adv) begin
        r_valid[r_scan] <= 1'b0;
        r_dirty[r_scan] <= 1'b0;
        r_scan          <= w_scan_last ? '0 : r_scan + 1'b1;
      end
      if (r_state == IDLE && bus.flush_2DC) r_scan <= '0;
    end
  end
  always_ff @(posedge CLK) begin
    if (w_store) r_data[w_idx] <= w_line;
    if (w_fill) begin
      r_data[w_idx] <= bus.block_read_fDM;
      r_tag[w_idx]  <= w_tag;
    end
  end
`ifdef DC_PERF_CNT_EN
  logic r_refilled;
  always_ff @(posedge CLK) begin
    if (RESET) begin
      hit_count  <= '0;
      miss_count <= '0;
      r_refilled <= 1'b0;
    end else begin
      r_refilled <= w_fill;
      if (w_serve && !r_refilled) hit_count <= hit_count + 32'd1;
      if (r_state == IDLE && (w_next == WRITEBACK || w_next == REFILL)) miss_count <= miss_count + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_data_cache.sv
// tb_data_cache: directed stimulus against an architectural memory model plus memory responder.
module tb_data_cache;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  data_cache_if dif();
`ifdef DC_PERF_CNT_EN
  logic [31:0] hc, mc;
`endif
  data_cache #(.LINES(32)) dut (
    .CLK(clk),
    .RESET(rst),
`ifdef DC_PERF_CNT_EN
    .hit_count(hc),
    .miss_count(mc),
`endif
    .bus(dif)
  );
  int n_vec = 0;
  int n_err = 0;
  int rd_delay = 0;
  int wb_delay = 0;
  int rd_count = 0;
  logic [31:0]  last_rd_addr = '0;
  logic [31:0]  arch [int unsigned];
  logic [31:0]  mem  [int unsigned];
  logic [31:0]  wb_addr [$];
  logic [255:0] wb_data [$];

  function automatic logic [31:0] dflt(int unsigned wa);
    return wa ^ 32'hC0DE_0000;
  endfunction
  function automatic logic [31:0] arch_rd(int unsigned wa);
    return arch.exists(wa) ? arch[wa] : dflt(wa);
  endfunction
  function automatic logic [31:0] mem_rd(int unsigned wa);
    return mem.exists(wa) ? mem[wa] : dflt(wa);
  endfunction
  function automatic logic [255:0] arch_blk(logic [31:0] a);
    logic [255:0] b;
    for (int k = 0; k < 8; k++) b[32*k +: 32] = arch_rd(int'(a >> 2) + k);
    return b;
  endfunction
  function automatic logic [255:0] mem_blk(logic [31:0] a);
    logic [255:0] b;
    for (int k = 0; k < 8; k++) b[32*k +: 32] = mem_rd(int'(a >> 2) + k);
    return b;
  endfunction
  function automatic void store_arch(logic [31:0] a, logic [31:0] d, logic [1:0] sz);
    int unsigned wa = int'(a >> 2);
    logic [31:0] w = arch_rd(wa);
    int n = (sz == 2'd0) ? 4 : int'(sz);
    for (int j = 0; j < n; j++) begin
      int lane = int'(a[1:0]) + j;
      if (lane < 4) w[8*(3-lane) +: 8] = d[8*(n-1-j) +: 8];
    end
    arch[wa] = w;
  endfunction

  task automatic chk(string nm, logic [255:0] act, logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Memory responder: answers each block request after the programmed delay.
  initial begin
    int cnt = 0;
    dif.block_read_fDM_valid = 1'b0;
    dif.block_write_fDM_valid = 1'b0;
    dif.block_read_fDM = '0;
    forever begin
      @(posedge clk);
      #1;
      dif.block_read_fDM_valid = 1'b0;
      dif.block_write_fDM_valid = 1'b0;
      if (rst || !(dif.dBlkRead || dif.dBlkWrite)) cnt = 0;
      else if (cnt < (dif.dBlkWrite ? wb_delay : rd_delay)) cnt++;
      else begin
        cnt = 0;
        if (dif.dBlkWrite) dif.block_write_fDM_valid = 1'b1;
        else begin
          dif.block_read_fDM = mem_blk(dif.block_address_2DM);
          dif.block_read_fDM_valid = 1'b1;
        end
      end
    end
  end

  // Per-cycle comparison against the architectural model.
  always @(negedge clk) if (!rst) begin
    chk("blk_excl", 256'(dif.dBlkRead & dif.dBlkWrite), 256'd0);
    if (!dif.dBlkRead && !dif.dBlkWrite) begin
      chk("blk_addr_idle", 256'(dif.block_address_2DM), 256'd0);
      chk("blk_wdata_idle", dif.block_write_2DM, 256'd0);
    end else chk("blk_align", 256'(dif.block_address_2DM[4:0]), 256'd0);
    if (dif.dBlkWrite && dif.block_write_fDM_valid) begin
      chk("wb_data", dif.block_write_2DM, arch_blk(dif.block_address_2DM));
      wb_addr.push_back(dif.block_address_2DM);
      wb_data.push_back(dif.block_write_2DM);
      for (int k = 0; k < 8; k++) mem[int'(dif.block_address_2DM >> 2) + k] = dif.block_write_2DM[32*k +: 32];
    end
    if (dif.dBlkRead && dif.block_read_fDM_valid) begin
      rd_count++;
      last_rd_addr = dif.block_address_2DM;
    end
    if (dif.flush_2DC) chk("flush_stall", 256'(dif.data_valid_fDC), 256'd0);
    if (!dif.data_valid_fDC) chk("rdata_stall", 256'(dif.data_read_fDC), 256'd0);
    else if (dif.read_2DC) chk("rdata", 256'(dif.data_read_fDC), 256'(arch_rd(int'(dif.data_address_2DC >> 2))));
    else if (dif.write_2DC) store_arch(dif.data_address_2DC, dif.data_write_2DC, dif.data_write_size_2DC);
    else chk("rdata_noreq", 256'(dif.data_read_fDC), 256'd0);
  end

  task automatic do_req(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                        input logic [1:0] sz, output int stall, output logic [31:0] rdata);
    dif.read_2DC = rd;
    dif.write_2DC = wr;
    dif.data_address_2DC = a;
    dif.data_write_2DC = d;
    dif.data_write_size_2DC = sz;
    stall = 0;
    while (1) begin
      @(negedge clk);
      if (dif.data_valid_fDC) break;
      stall++;
      if (stall > 300) begin
        n_vec++;
        n_err++;
        $display("FAIL req_timeout: addr %0h got no completion in 300 cycles", a);
        break;
      end
    end
    rdata = dif.data_read_fDC;
    @(posedge clk);
    #1;
    dif.read_2DC = 1'b0;
    dif.write_2DC = 1'b0;
  endtask

  task automatic do_flush(output int cyc);
    dif.flush_2DC = 1'b1;
    cyc = 0;
    while (1) begin
      @(negedge clk);
      if (dif.flush_done) break;
      cyc++;
      if (cyc > 500) begin
        n_vec++;
        n_err++;
        $display("FAIL flush_timeout: no flush_done in 500 cycles");
        break;
      end
    end
    @(posedge clk);
    #1;
    dif.flush_2DC = 1'b0;
    @(negedge clk);
    chk("flush_done_pulse", 256'(dif.flush_done), 256'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic rd_chk(string nm, logic [31:0] a, int exp_stall, logic [31:0] exp_data);
    int st;
    logic [31:0] rdv;
    do_req(1'b1, 1'b0, a, 32'd0, 2'd0, st, rdv);
    chk({nm, "_stall"}, 256'(st), 256'(exp_stall));
    chk({nm, "_data"}, 256'(rdv), 256'(exp_data));
  endtask

  task automatic wr_chk(string nm, logic [31:0] a, logic [31:0] d, logic [1:0] sz, int exp_stall);
    int st;
    logic [31:0] rdv;
    do_req(1'b0, 1'b1, a, d, sz, st, rdv);
    chk({nm, "_stall"}, 256'(st), 256'(exp_stall));
  endtask

  initial begin
    int cyc;
    int nwb;
    dif.read_2DC = 1'b0;
    dif.write_2DC = 1'b0;
    dif.flush_2DC = 1'b0;
    dif.data_address_2DC = '0;
    dif.data_write_2DC = '0;
    dif.data_write_size_2DC = '0;
    for (int k = 0; k < 8; k++) begin
      mem[32'h40 + k] = 32'hA0 + k;
      arch[32'h40 + k] = 32'hA0 + k;
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_valid", 256'(dif.data_valid_fDC), 256'd1);
    chk("reset_rdata", 256'(dif.data_read_fDC), 256'd0);
    chk("reset_blkrd", 256'(dif.dBlkRead), 256'd0);
    chk("reset_fdone", 256'(dif.flush_done), 256'd0);
    @(posedge clk);
    #1;
    rd_chk("cold_100", 32'h100, 2, 32'h0000_00A0);
    chk("cold_100_addr", 256'(last_rd_addr), 256'h100);
    rd_chk("hit_11c", 32'h11C, 0, 32'h0000_00A7);
    wr_chk("st_b_101", 32'h101, 32'h55, 2'd1, 0);
    rd_chk("rd_100", 32'h100, 0, 32'h0055_00A0);
    wr_chk("st_w_104", 32'h104, 32'hDEAD_BEEF, 2'd0, 0);
    rd_chk("rd_104", 32'h104, 0, 32'hDEAD_BEEF);
    wr_chk("st_h_10b", 32'h10B, 32'h1234, 2'd2, 0);
    rd_chk("rd_108", 32'h108, 0, 32'h0000_0012);
    wr_chk("st_t_10c", 32'h10C, 32'h00AB_CDEF, 2'd3, 0);
    rd_chk("rd_10c", 32'h10C, 0, 32'hABCD_EFA3);
    wb_delay = 2;
    rd_delay = 10;
    rd_chk("dirty_1100", 32'h1100, 15, 32'hC0DE_0440);
    chk("dirty_wb_n", 256'(wb_addr.size()), 256'd1);
    chk("dirty_wb_addr", 256'(wb_addr[0]), 256'h100);
    chk("dirty_wb_w0", 256'(wb_data[0][31:0]), 256'h0055_00A0);
    chk("dirty_wb_w1", 256'(wb_data[0][63:32]), 256'hDEAD_BEEF);
    chk("dirty_rd_addr", 256'(last_rd_addr), 256'h1100);
    wb_delay = 0;
    rd_delay = 1;
    wr_chk("st_0", 32'h0, 32'h1111_1111, 2'd0, 3);
    wr_chk("st_3e0", 32'h3E0, 32'h2222_2222, 2'd0, 3);
    nwb = wb_addr.size();
    do_flush(cyc);
    chk("flush_cycles", 256'(cyc), 256'd35);
    chk("flush_wb_n", 256'(wb_addr.size() - nwb), 256'd2);
    if (wb_addr.size() >= nwb + 2) begin
      chk("flush_wb0_addr", 256'(wb_addr[nwb]), 256'h0);
      chk("flush_wb1_addr", 256'(wb_addr[nwb+1]), 256'h3E0);
    end
    do_flush(cyc);
    chk("flush_clean_cycles", 256'(cyc), 256'd33);
    rd_chk("post_flush_0", 32'h0, 3, 32'h1111_1111);
    rd_chk("post_flush_3e0", 32'h3E0, 3, 32'h2222_2222);
    rd_chk("post_flush_1100", 32'h1100, 3, 32'hC0DE_0440);
    rd_delay = 50;
    dif.read_2DC = 1'b1;
    dif.data_address_2DC = 32'h2000;
    cyc = 0;
    while (!dif.dBlkRead && cyc < 10) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("mid_refill_reached", 256'(dif.dBlkRead), 256'd1);
    rst = 1'b1;
    dif.read_2DC = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_blkrd", 256'(dif.dBlkRead), 256'd0);
    chk("rst_blkwr", 256'(dif.dBlkWrite), 256'd0);
    chk("rst_valid", 256'(dif.data_valid_fDC), 256'd1);
    chk("rst_baddr", 256'(dif.block_address_2DM), 256'd0);
`ifdef DC_PERF_CNT_EN
    chk("rst_hits", 256'(hc), 256'd0);
    chk("rst_misses", 256'(mc), 256'd0);
`endif
    @(posedge clk);
    #1;
    rd_delay = 2;
    rd_chk("rerd_2000", 32'h2000, 4, 32'hC0DE_0800);
    rd_chk("rerd_0", 32'h0, 4, 32'h1111_1111);
    rd_chk("hit_0", 32'h0, 0, 32'h1111_1111);
`ifdef DC_PERF_CNT_EN
    chk("perf_hits", 256'(hc), 256'd1);
    chk("perf_misses", 256'(mc), 256'd2);
`endif
    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule
